cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 140 ++++++++++++++
 tb/tb_cache_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Blocking write-through, no-write-allocate cache controller between a CPU port, a cache and a memory port.
// Optional hit/miss performance counters are enabled by defining CACHE_CTRL_PERF_EN.
module cache_ctrl #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cpu_req_i,
  input  logic                      cpu_we_i,
  input  logic [DATA_WIDTH/8-1:0]   cpu_be_i,
  input  logic [ADDRESS_WIDTH-1:0]  cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     cpu_rdata_o,
  output logic [ADDRESS_WIDTH-1:0]  cache_addr_o,
  output logic [DATA_WIDTH-1:0]     cache_wd_o,
  output logic [DATA_WIDTH/8-1:0]   cache_we_o,
  output logic                      cache_fill_o,
  output logic [DATA_WIDTH-1:0]     cache_found_o,
  input  logic                      cache_hit_i,
  input  logic [DATA_WIDTH-1:0]     cache_rd_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic                      mem_ack_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
`ifdef CACHE_CTRL_PERF_EN
  output logic [31:0]               hit_cnt_o,
  output logic [31:0]               miss_cnt_o,
`endif
  output logic [2:0]                dbg_state_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_FILL   = 3'd3,
    S_MEM_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [BE_W-1:0]          r_be;
  logic                     r_we;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [DATA_WIDTH-1:0]    r_found;
  logic                     w_lookup;

  assign w_lookup = (r_state == S_LOOKUP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_found <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cpu_req_i) begin
        r_addr  <= cpu_addr_i;
        r_wdata <= cpu_wdata_i;
        r_be    <= cpu_be_i;
        r_we    <= cpu_we_i;
      end
      if (w_lookup && !r_we && cache_hit_i) begin
        r_rdata <= cache_rd_i;
      end
      if (r_state == S_MEM_RD && mem_ack_i) begin
        r_rdata <= mem_rdata_i;
        r_found <= mem_rdata_i;
      end
    end
  end

  // cache_hit_i is only meaningful in LOOKUP, so it is consulted nowhere else.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cpu_req_i) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (r_we)             w_next = (r_be == '0) ? S_DONE : S_MEM_WR;
        else if (cache_hit_i) w_next = S_DONE;
        else                  w_next = S_MEM_RD;
      end
      S_MEM_RD: if (mem_ack_i) w_next = S_FILL;
      S_FILL:   w_next = S_DONE;
      S_MEM_WR: if (mem_ack_i) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign cpu_rdata_o   = r_rdata;
  assign cache_addr_o  = (r_state == S_IDLE) ? cpu_addr_i  : r_addr;
  assign cache_wd_o    = (r_state == S_IDLE) ? cpu_wdata_i : r_wdata;
  // Gated by the hit so a write miss never touches the cache arrays.
  assign cache_we_o    = (w_lookup && r_we && cache_hit_i) ? r_be : '0;
  assign cache_fill_o  = (r_state == S_FILL);
  assign cache_found_o = r_found;
  assign mem_req_o     = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign mem_we_o      = (r_state == S_MEM_WR);
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign mem_be_o      = r_be;
  assign dbg_state_o   = r_state;

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_lookup && !r_we) begin
      if (cache_hit_i && r_hit_cnt != 32'hFFFF_FFFF)    r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (!cache_hit_i && r_miss_cnt != 32'hFFFF_FFFF)  r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Table-driven bench for cache_ctrl: a memory/cache responder per vector, a read-data scoreboard,
// and hand-written sequences for reset and mid-transaction abort.
module tb_cache_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req_i, cpu_we_i;
  logic [3:0]  cpu_be_i;
  logic [16:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        busy_o, done_o;
  logic [31:0] cpu_rdata_o;
  logic [16:0] cache_addr_o;
  logic [31:0] cache_wd_o;
  logic [3:0]  cache_we_o;
  logic        cache_fill_o;
  logic [31:0] cache_found_o;
  logic        cache_hit_i;
  logic [31:0] cache_rd_i;
  logic        mem_req_o, mem_we_o;
  logic [16:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [2:0]  dbg_state_o;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  cache_ctrl dut (
    .CLK(CLK), .RST(RST),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .busy_o(busy_o), .done_o(done_o), .cpu_rdata_o(cpu_rdata_o),
    .cache_addr_o(cache_addr_o), .cache_wd_o(cache_wd_o), .cache_we_o(cache_we_o),
    .cache_fill_o(cache_fill_o), .cache_found_o(cache_found_o),
    .cache_hit_i(cache_hit_i), .cache_rd_i(cache_rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
`ifdef CACHE_CTRL_PERF_EN
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] crd;
    int          dly;       // cycles of mem_req_o before mem_ack_i
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_cwe;
    int          exp_req_cyc;
    int          exp_fill;
    int          exp_lat;   // negedges from request drive to done_o
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, exp);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   cyc, req_cyc, fill_cnt, cwe_cnt;
    logic [3:0] cwe_seen;
    logic mem_ok, addr_ok, done_seen, busy_ok;
    logic [31:0] exp_rd;
    v = vecs[i];
    cyc = 0; req_cyc = 0; fill_cnt = 0; cwe_cnt = 0; cwe_seen = 4'h0;
    mem_ok = 1'b1; addr_ok = 1'b1; done_seen = 1'b0; busy_ok = 1'b1;
    @(negedge CLK);
    cpu_req_i = 1'b1; cpu_we_i = v.we; cpu_be_i = v.be;
    cpu_addr_i = v.addr; cpu_wdata_i = v.wdata;
    cache_hit_i = v.hit; cache_rd_i = v.crd;
    exp_q.push_back(v.exp_rdata);
    if (!v.we && v.hit)  exp_hits++;
    if (!v.we && !v.hit) exp_miss++;
    while (!done_seen && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (cache_we_o != 4'h0) begin cwe_seen = cache_we_o; cwe_cnt++; end
      if (dbg_state_o == 3'd1 && (cache_addr_o != v.addr || cache_wd_o != v.wdata)) addr_ok = 1'b0;
      if (cache_fill_o) fill_cnt++;
      if (!busy_o) busy_ok = 1'b0;
      if (mem_req_o) begin
        req_cyc++;
        if (mem_addr_o != v.addr || mem_we_o != v.we) mem_ok = 1'b0;
        if (v.we && (mem_wdata_o != v.wdata || mem_be_o != v.be)) mem_ok = 1'b0;
        mem_ack_i   = (req_cyc - 1 == v.dly);
        mem_rdata_i = mem_ack_i ? v.mrd : $urandom;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
      end
      if (done_o) begin
        done_seen = 1'b1;
        cpu_req_i = 1'b0;
        exp_rd = exp_q.pop_front();
        check($sformatf("v%0d rdata", i), cpu_rdata_o, exp_rd);
      end else begin
        // Scramble CPU inputs while busy; the latched request must be unaffected.
        cpu_addr_i  = 17'($urandom);
        cpu_wdata_i = $urandom;
        cpu_be_i    = 4'($urandom);
        cpu_we_i    = 1'($urandom);
      end
    end
    check($sformatf("v%0d done_seen", i), 32'(done_seen), 32'd1);
    check($sformatf("v%0d latency", i), 32'(cyc), 32'(v.exp_lat));
    check($sformatf("v%0d cache_we", i), 32'(cwe_seen), 32'(v.exp_cwe));
    check($sformatf("v%0d cache_we_cycles", i), 32'(cwe_cnt), (v.exp_cwe != 4'h0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d mem_req_cycles", i), 32'(req_cyc), 32'(v.exp_req_cyc));
    check($sformatf("v%0d fill_pulses", i), 32'(fill_cnt), 32'(v.exp_fill));
    check($sformatf("v%0d mem_outputs_stable", i), 32'(mem_ok), 32'd1);
    check($sformatf("v%0d cache_addr_latched", i), 32'(addr_ok), 32'd1);
    check($sformatf("v%0d busy_held", i), 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int   cyc, fill_cnt, done_cnt;
    logic req_seen;
    //            we   be     addr       wdata         hit  crd           dly mrd           exp_rdata     cwe   req fill lat
    vecs[0] = '{1'b0, 4'h0, 17'h00010, 32'h0,        1'b0, 32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 4, 1, 7};
    vecs[1] = '{1'b0, 4'hF, 17'h00010, 32'h0,        1'b1, 32'hDEADBEEF, 0, 32'h0,        32'hDEADBEEF, 4'h0, 0, 0, 2};
    vecs[2] = '{1'b1, 4'h3, 17'h00010, 32'h0000CAFE, 1'b1, 32'h0,        0, 32'h0,        32'hDEADBEEF, 4'h3, 1, 0, 3};
    vecs[3] = '{1'b1, 4'hF, 17'h001F0, 32'h12345678, 1'b0, 32'h0,        2, 32'h0,        32'hDEADBEEF, 4'h0, 3, 0, 5};
    vecs[4] = '{1'b1, 4'h0, 17'h00020, 32'h87654321, 1'b0, 32'h0,        0, 32'h0,        32'hDEADBEEF, 4'h0, 0, 0, 2};
    vecs[5] = '{1'b0, 4'h0, 17'h0AAAC, 32'h0,        1'b1, 32'h55AA33CC, 0, 32'h0,        32'h55AA33CC, 4'h0, 0, 0, 2};
    vecs[6] = '{1'b0, 4'h0, 17'h1FFFC, 32'h0,        1'b0, 32'h0,        0, 32'hA5A50F0F, 32'hA5A50F0F, 4'h0, 1, 1, 4};
    vecs[7] = '{1'b1, 4'h8, 17'h0AAAC, 32'hFF000000, 1'b1, 32'h0,        1, 32'h0,        32'hA5A50F0F, 4'h8, 2, 0, 4};

    RST = 1'b1; cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_be_i = 4'h0;
    cpu_addr_i = 17'h01234; cpu_wdata_i = 32'h0BADF00D;
    cache_hit_i = 1'b0; cache_rd_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) @(negedge CLK);
    check("rst state", 32'(dbg_state_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst mem_req", 32'(mem_req_o), 32'd0);
    check("rst mem_we", 32'(mem_we_o), 32'd0);
    check("rst fill", 32'(cache_fill_o), 32'd0);
    check("rst cache_we", 32'(cache_we_o), 32'd0);
    check("rst rdata", cpu_rdata_o, 32'd0);
    check("rst found", cache_found_o, 32'd0);
    check("rst mem_addr", 32'(mem_addr_o), 32'd0);
    check("idle cache_addr passthru", 32'(cache_addr_o), 32'h01234);
    check("idle cache_wd passthru", cache_wd_o, 32'h0BADF00D);
    cpu_req_i = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    check("idle without req", 32'(dbg_state_o), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i);
    check("fill data after v6", cache_found_o, 32'hA5A50F0F);
`ifdef CACHE_CTRL_PERF_EN
    check("perf hit_cnt", hit_cnt_o, 32'(exp_hits));
    check("perf miss_cnt", miss_cnt_o, 32'(exp_miss));
`endif

    // Abort a read miss with RST while MEM_RD waits, then send a late ack.
    @(negedge CLK);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 17'h00100; cache_hit_i = 1'b0;
    cyc = 0; req_seen = 1'b0;
    while (!req_seen && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      cpu_req_i = 1'b0;
      req_seen = mem_req_o;
    end
    check("abort reached MEM_RD", 32'(req_seen), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort mem_req low", 32'(mem_req_o), 32'd0);
    check("abort state idle", 32'(dbg_state_o), 32'd0);
    RST = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h13579BDF;
    fill_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (cache_fill_o) fill_cnt++;
      if (done_o) done_cnt++;
    end
    mem_ack_i = 1'b0;
    check("abort no fill", 32'(fill_cnt), 32'd0);
    check("abort no done", 32'(done_cnt), 32'd0);
    check("abort still idle", 32'(dbg_state_o), 32'd0);
    check("abort busy low", 32'(busy_o), 32'd0);
    check("abort rdata cleared", cpu_rdata_o, 32'd0);
    check("abort found cleared", cache_found_o, 32'd0);
`ifdef CACHE_CTRL_PERF_EN
    check("perf hit_cnt cleared", hit_cnt_o, 32'd0);
    check("perf miss_cnt cleared", miss_cnt_o, 32'd0);
`endif
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
